// File: rtl/fp_std_arbiter_pkg.sv
// fp_std_arbiter_pkg: shared types and defaults for the FP standardiser arbiter
package fp_std_arbiter_pkg;
  typedef logic [4:0] func5_t;
  localparam func5_t CVTFR = 5'h0c;
  localparam int STD_LATENCY_DEFAULT = 3;
  typedef enum logic {SRC_CORDIC, SRC_FADD} std_src_e;
  typedef struct packed {
    func5_t      func5;
    logic [25:0] result;
    logic        override;
    logic [17:0] override_val;
  } cordic_req_t;
  typedef struct packed {
    func5_t      func5;
    logic        sign;
    logic [6:0]  exponent;
    logic [17:0] mantissa;
  } fadd_req_t;
endpackage

// File: rtl/fp_std_req_fifo.sv
// fp_std_req_fifo: small synchronous FIFO with combinational head
module fp_std_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  assign wr = push & ~full;
  assign rd = pop & ~empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/fp_std_arbiter.sv
// fp_std_arbiter: round-robin issue of CORDIC/FADD results to the shared standardiser,
// with source tagging aligned to the standardiser's fixed latency
module fp_std_arbiter
  import fp_std_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int STD_LATENCY = STD_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cordic_valid,
  output logic        cordic_ready,
  input  func5_t      cordic_func5,
  input  logic [25:0] cordic_result,
  input  logic        cordic_override,
  input  logic [17:0] cordic_override_val,
  input  logic        fadd_valid,
  output logic        fadd_ready,
  input  func5_t      fadd_func5,
  input  logic        fadd_sign,
  input  logic [6:0]  fadd_exponent,
  input  logic [17:0] fadd_mantissa,
  output func5_t      std_func5,
  output logic        std_valid_cordic,
  output logic [25:0] std_result_cordic,
  output logic        std_override_cordic,
  output logic [17:0] std_override_cordic_val,
  output logic        std_valid_fadd,
  output logic        std_fadd_sign,
  output logic [6:0]  std_fadd_exponent,
  output logic [17:0] std_fadd_mantissa,
  input  logic        valid_std,
  output logic        res_src,
  output logic        tag_err
);
  cordic_req_t c_in, c_head;
  fadd_req_t f_in, f_head;
  logic c_full, c_empty, f_full, f_empty, c_g, f_g;
  std_src_e prio;
  logic [STD_LATENCY-1:0] pv, ps;
  assign c_in = '{cordic_func5, cordic_result, cordic_override, cordic_override_val};
  assign f_in = '{fadd_func5, fadd_sign, fadd_exponent, fadd_mantissa};
  assign cordic_ready = ~c_full & ~rst;
  assign fadd_ready = ~f_full & ~rst;
  assign c_g = ~c_empty & (f_empty | prio == SRC_CORDIC);
  assign f_g = ~f_empty & ~c_g;
  assign res_src = pv[STD_LATENCY-1] & ps[STD_LATENCY-1];
  fp_std_req_fifo #(.WIDTH($bits(cordic_req_t)), .DEPTH(FIFO_DEPTH)) u_cordic_fifo (
    .clk(clk), .rst(rst), .push(cordic_valid & cordic_ready), .pop(c_g),
    .din(c_in), .dout(c_head), .full(c_full), .empty(c_empty)
  );
  fp_std_req_fifo #(.WIDTH($bits(fadd_req_t)), .DEPTH(FIFO_DEPTH)) u_fadd_fifo (
    .clk(clk), .rst(rst), .push(fadd_valid & fadd_ready), .pop(f_g),
    .din(f_in), .dout(f_head), .full(f_full), .empty(f_empty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prio <= SRC_CORDIC;
      std_func5 <= '0;
      std_valid_cordic <= 1'b0;
      std_result_cordic <= '0;
      std_override_cordic <= 1'b0;
      std_override_cordic_val <= '0;
      std_valid_fadd <= 1'b0;
      std_fadd_sign <= 1'b0;
      std_fadd_exponent <= '0;
      std_fadd_mantissa <= '0;
    end else begin
      if (c_g | f_g) prio <= c_g ? SRC_FADD : SRC_CORDIC;
      std_func5 <= c_g ? c_head.func5 : f_g ? f_head.func5 : '0;
      std_valid_cordic <= c_g;
      std_result_cordic <= c_g ? c_head.result : '0;
      std_override_cordic <= c_g & c_head.override;
      std_override_cordic_val <= c_g ? c_head.override_val : '0;
      std_valid_fadd <= f_g;
      std_fadd_sign <= f_g & f_head.sign;
      std_fadd_exponent <= f_g ? f_head.exponent : '0;
      std_fadd_mantissa <= f_g ? f_head.mantissa : '0;
    end
  // Tag pipe is fed from the registered issue so its tail lines up with valid_std.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= '0;
      ps <= '0;
      tag_err <= 1'b0;
    end else begin
      pv[0] <= std_valid_cordic | std_valid_fadd;
      ps[0] <= std_valid_fadd;
      for (int i = 1; i < STD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
      end
      tag_err <= tag_err | (valid_std != pv[STD_LATENCY-1]);
    end
endmodule
